prefix_add_sched: RTL and testbench

PREFIX_ADD_SCHED -- requirements
Module: prefix_add_sched

---
 rtl/prefix_pkg.sv | 12 +
 rtl/prefix_adder32.sv | 35 +++
 rtl/prefix_add_sched.sv | 125 ++++++++++++
 tb/tb_prefix_add_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared types and constants for the prefix-adder scheduler slice.
package prefix_pkg;

   localparam int unsigned PFX_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

endpackage

// File: rtl/prefix_adder32.sv
// Combinational 32-bit Kogge-Stone prefix adder with carry-in and carry-out.
module prefix_adder32
   import prefix_pkg::*;
(
   input  logic [PFX_W-1:0] a,
   input  logic [PFX_W-1:0] b,
   input  logic             cin,
   output logic [PFX_W-1:0] sum,
   output logic             cout
);

   localparam int unsigned LVLS = 5;
   localparam int unsigned DFIN = 1 << (LVLS - 1);

   logic [PFX_W-1:0] g_fin;

   // Carry-in is folded into bit 0's generate, so g_fin[i] is the carry out of bit i.
   for (genvar l = 0; l < LVLS; l++) begin : lvl
      logic [PFX_W-1:0] g;
      logic [PFX_W-1:0] p;
      if (l == 0) begin : base
         assign p = a ^ b;
         assign g = {a[PFX_W-1:1] & b[PFX_W-1:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
      end else begin : span
         localparam int unsigned D = 1 << (l - 1);
         assign g = lvl[l-1].g | (lvl[l-1].p & {lvl[l-1].g[PFX_W-1-D:0], {D{1'b0}}});
         assign p = lvl[l-1].p & {lvl[l-1].p[PFX_W-1-D:0], {D{1'b1}}};
      end
   end

   assign g_fin = lvl[LVLS-1].g | (lvl[LVLS-1].p & {lvl[LVLS-1].g[PFX_W-1-DFIN:0], {DFIN{1'b0}}});
   assign sum   = lvl[0].p ^ {g_fin[PFX_W-2:0], cin};
   assign cout  = g_fin[PFX_W-1];

endmodule

// File: rtl/prefix_add_sched.sv
// Two-requester round-robin scheduler around a shared prefix adder.
// Define PFX_SUB_EN to add per-requester subtract inputs (req0_sub/req1_sub).
module prefix_add_sched
   import prefix_pkg::*;
#(
   parameter int unsigned RR_INIT = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [PFX_W-1:0] req0_a,
   input  logic [PFX_W-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [PFX_W-1:0] req1_a,
   input  logic [PFX_W-1:0] req1_b,
   input  logic             req1_cin,
`ifdef PFX_SUB_EN
   input  logic             req0_sub,
   input  logic             req1_sub,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [PFX_W-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id
);

   localparam logic RR_PTR = 1'(RR_INIT);

   state_t           state;
   logic             ptr;
   logic             grant0;
   logic             grant1;
   logic [PFX_W-1:0] sel_a;
   logic [PFX_W-1:0] sel_b;
   logic             sel_cin;
   logic [PFX_W-1:0] op_a;
   logic [PFX_W-1:0] op_b;
   logic             op_cin;
   logic             op_id;
   logic [PFX_W-1:0] add_sum;
   logic             add_cout;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !rst) begin
         if (req0_valid && (!req1_valid || !ptr))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Subtract is folded in at capture time so the adder only ever sees a + b + cin.
   always_comb begin
      sel_a   = grant1 ? req1_a   : req0_a;
      sel_b   = grant1 ? req1_b   : req0_b;
      sel_cin = grant1 ? req1_cin : req0_cin;
`ifdef PFX_SUB_EN
      if (grant1 ? req1_sub : req0_sub) begin
         sel_b   = ~sel_b;
         sel_cin = 1'b1;
      end
`endif
   end

   prefix_adder32 u_adder (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= RR_PTR;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_cin    <= 1'b0;
         op_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  op_cin <= sel_cin;
                  op_id  <= grant1;
                  ptr    <= grant0;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_sum   <= add_sum;
               rsp_cout  <= add_cout;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prefix_add_sched.sv
// Directed scoreboard bench for prefix_add_sched (RR_INIT = 0).
module tb_prefix_add_sched;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        id;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [31:0] req0_a = '0;
   logic [31:0] req0_b = '0;
   logic        req0_cin = 1'b0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [31:0] req1_a = '0;
   logic [31:0] req1_b = '0;
   logic        req1_cin = 1'b0;
`ifdef PFX_SUB_EN
   logic        req0_sub = 1'b0;
   logic        req1_sub = 1'b0;
`endif
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_sum;
   logic        rsp_cout;
   logic        rsp_id;

   rsp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   prefix_add_sched #(.RR_INIT(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
`ifdef PFX_SUB_EN
      .req0_sub   (req0_sub),
      .req1_sub   (req1_sub),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id)
   );

   function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input logic id);
      logic [32:0] s;
      rsp_t r;
      if (sub) begin
         s = {1'b0, a} - {1'b0, b};
         r.cout = ~s[32];
      end else begin
         s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         r.cout = s[32];
      end
      r.sum = s[31:0];
      r.id  = id;
      return r;
   endfunction

   function automatic logic sub_of(input logic which);
`ifdef PFX_SUB_EN
      return which ? req1_sub : req0_sub;
`else
      return which & 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the falling edge: logs accepted requests and scores delivered results.
   task automatic tick();
      rsp_t e;
      if (req0_valid && req0_ready)
         sb.push_back(model(req0_a, req0_b, req0_cin, sub_of(1'b0), 1'b0));
      if (req1_valid && req1_ready)
         sb.push_back(model(req1_a, req1_b, req1_cin, sub_of(1'b1), 1'b1));
      if (rsp_valid && rsp_ready) begin
         chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_sum",  64'(rsp_sum),  64'(e.sum));
            chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
            chk("rsp_id",   64'(rsp_id),   64'(e.id));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
      chk("rst_rsp_cout",  64'(rsp_cout),  64'd0);
      chk("rst_rsp_id",    64'(rsp_id),    64'd0);
      chk("rst_ready",     64'({req0_ready, req1_ready}), 64'd0);
      sb.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 12 && sb.size() != 0; i++) begin
         @(negedge clk);
         tick();
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single request latency, HOLD stability, deferred req1 grant.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_b = 32'hFFFF_FFFF; req0_cin = 1'b0;
      @(negedge clk);
      chk("a_grant0", 64'({req0_ready, req1_ready}), 64'b10);
      tick();
      req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
      req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h0; req1_cin = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("a_exec_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("a_exec_ready1",    64'(req1_ready), 64'd0);
      tick();
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("a_hold_valid", 64'(rsp_valid),  64'd1);
         chk("a_hold_sum",   64'(rsp_sum),    64'h0000_0000);
         chk("a_hold_cout",  64'(rsp_cout),   64'd1);
         chk("a_hold_id",    64'(rsp_id),     64'd0);
         chk("a_hold_ready", 64'(req1_ready), 64'd0);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("a_req1_after_idle", 64'({req0_ready, req1_ready}), 64'b01);
      chk("a_idle_rsp_valid",  64'(rsp_valid), 64'd0);
      tick();
      drain();

      // Both valid from reset: grants alternate 0,1,0,1 every 3 cycles.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0; req0_cin = 1'b1;
      req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h9ABC_DEF0; req1_cin = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("b_ready0", 64'(req0_ready), 64'((k % 3 == 0) && ((k / 3) % 2 == 0)));
         chk("b_ready1", 64'(req1_ready), 64'((k % 3 == 0) && ((k / 3) % 2 == 1)));
         tick();
      end
      drain();

      // Reset during EXEC discards the operation and restores the pointer.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_cin = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("c_grant0", 64'(req0_ready), 64'd1);
      tick();
      req0_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("c_no_stale", 64'(rsp_valid), 64'd0);
         tick();
      end
      req0_valid = 1'b1; req0_a = 32'd9;  req0_b = 32'd10;
      req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd30; req1_cin = 1'b0;
      @(negedge clk);
      chk("c_ptr_restored", 64'({req0_ready, req1_ready}), 64'b10);
      tick();
      drain();

`ifdef PFX_SUB_EN
      // Subtract mode; req_cin is ignored when sub is set.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_cin = 1'b1; req0_sub = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      tick();
      drain();
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd5; req1_cin = 1'b0; req1_sub = 1'b1;
      @(negedge clk);
      tick();
      drain();
      req0_sub = 1'b0;
      req1_sub = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
